// File: rtl/spi_pkg.sv
// Frame layout constants, FSM state type and the command-word builder shared by the SPI master.
package spi_pkg;

   localparam int WORD_W   = 32;
   localparam int RWB_BIT  = 0;
   localparam int ADDR_LSB = 8;
   localparam int ADDR_W   = 6;
   localparam int DATA_LSB = 16;
   localparam int DATA_W   = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      GAP  = 2'd3
   } state_t;

   function automatic logic [WORD_W-1:0] build_cmd_word(
      input logic              rwb,
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] data
   );
      logic [WORD_W-1:0] w;
      w = '0;
      w[RWB_BIT] = rwb;
      w[ADDR_LSB +: ADDR_W] = addr;
      w[DATA_LSB +: DATA_W] = data;
      return w;
   endfunction

endpackage

// File: rtl/spi_ms_tick.sv
// Half-period timer: a down-counter that pulses tick on the DIV-th consecutive enabled cycle.
module spi_ms_tick
   import spi_pkg::*;
#(
   parameter int DIV = 2
) (
   input  logic sys_clk,
   input  logic rstn,
   input  logic en,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LOAD = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // Held at LOAD while disabled so the first enabled cycle starts a full period.
   always_ff @(posedge sys_clk) begin
      if (!rstn) begin
         cnt <= LOAD;
      end else if (!en || tick) begin
         cnt <= LOAD;
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tick = en && (cnt == '0);

endmodule

// File: rtl/spi_ms.sv
// SPI master for 32-bit command frames: LSB first, sclk idles low, miso sampled on sclk rise.
// Build option SPI_MS_LOOPBACK_EN samples the outgoing mosi instead of the miso pin.
//
// state | meaning
// IDLE  | cs_n high, ready for a request
// LOW   | sclk low half-period, mosi holds current bit
// HIGH  | sclk high half-period, current bit already sampled
// GAP   | cs_n high recovery time after a frame
module spi_ms
   import spi_pkg::*;
#(
   parameter int CLK_DIV    = 2,
   parameter int GAP_CYCLES = 4
) (
   input  logic                sys_clk,
   input  logic                rstn,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_rwb,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_data,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_data,
   output logic                sclk,
   output logic                cs_n,
   output logic                mosi,
   input  logic                miso
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES - 1);
   localparam logic [4:0]    LAST_BIT   = 5'(WORD_W - 1);
   localparam logic [4:0]    DATA_FIRST = 5'(DATA_LSB);
   localparam logic [4:0]    DATA_LAST  = 5'(DATA_LSB + DATA_W - 1);

   state_t              state, state_nxt;
   logic [WORD_W-1:0]   cmd, word;
   logic [DATA_W-1:0]   rx_data;
   logic [4:0]          bit_cnt, bit_nxt;
   logic [GW-1:0]       gap_cnt;
   logic                tick, accept, rise, step, last, sample_bit, in_data;

   spi_ms_tick #(.DIV(CLK_DIV)) u_tick (
      .sys_clk (sys_clk),
      .rstn    (rstn),
      .en      ((state == LOW) || (state == HIGH)),
      .tick    (tick)
   );

   assign cmd       = build_cmd_word(req_rwb, req_addr, req_data);
   assign bit_nxt   = bit_cnt + 5'd1;
   assign in_data   = (bit_cnt >= DATA_FIRST) && (bit_cnt <= DATA_LAST);
   assign req_ready = (state == IDLE);

`ifdef SPI_MS_LOOPBACK_EN
   assign sample_bit = mosi;
`else
   assign sample_bit = miso;
`endif

   always_ff @(posedge sys_clk) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      rise      = 1'b0;
      step      = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: if (req_valid) begin
            accept    = 1'b1;
            state_nxt = LOW;
         end
         LOW: if (tick) begin
            rise      = 1'b1;
            state_nxt = HIGH;
         end
         HIGH: if (tick) begin
            if (bit_cnt == LAST_BIT) begin
               last      = 1'b1;
               state_nxt = GAP;
            end else begin
               step      = 1'b1;
               state_nxt = LOW;
            end
         end
         GAP: if (gap_cnt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Only the data field is ever reported, so it is shifted in LSB first rather than storing all 32 bits.
   always_ff @(posedge sys_clk) begin
      if (!rstn) begin
         word      <= '0;
         rx_data   <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= GAP_LOAD;
         sclk      <= 1'b0;
         cs_n      <= 1'b1;
         mosi      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= last;
         if (accept) begin
            word    <= cmd;
            bit_cnt <= '0;
            cs_n    <= 1'b0;
            mosi    <= cmd[0];
         end
         if (rise) begin
            sclk <= 1'b1;
            if (in_data) rx_data <= {sample_bit, rx_data[DATA_W-1:1]};
         end
         if (step) begin
            sclk    <= 1'b0;
            bit_cnt <= bit_nxt;
            mosi    <= word[bit_nxt];
         end
         if (last) begin
            sclk     <= 1'b0;
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
            rsp_data <= rx_data;
            gap_cnt  <= GAP_LOAD;
         end else if ((state == GAP) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_ms.sv
// Self-checking bench for spi_ms: directed table, random frames against a word-level model, corner sequences.
`timescale 1ns/1ps
module tb_spi_ms;

   localparam int CLK_DIV    = 2;
   localparam int GAP_CYCLES = 4;
`ifdef SPI_MS_LOOPBACK_EN
   localparam bit LOOPBACK = 1'b1;
`else
   localparam bit LOOPBACK = 1'b0;
`endif

   typedef struct {
      logic        rwb;
      logic [5:0]  addr;
      logic [11:0] data;
      logic [31:0] miso_word;
      logic [31:0] exp_word;
      logic [11:0] exp_rsp;
   } vec_t;

   typedef struct {
      logic [31:0] mosi_word;
      int          cs_low;
      int          rises;
      int          pulses;
      int          ready_hi;
      logic [11:0] rsp;
      bit          timeout;
   } obs_t;

   logic        sys_clk = 1'b0;
   logic        rstn, req_valid, req_rwb, miso;
   logic [5:0]  req_addr;
   logic [11:0] req_data;
   logic        req_ready, rsp_valid, sclk, cs_n, mosi;
   logic [11:0] rsp_data;

   logic        req_valid_1, req_rwb_1, miso_1;
   logic [5:0]  req_addr_1;
   logic [11:0] req_data_1;
   logic        req_ready_1, rsp_valid_1, sclk_1, cs_n_1, mosi_1;
   logic [11:0] rsp_data_1;

   int tests = 0;
   int fails = 0;

   always #5 sys_clk = ~sys_clk;

   spi_ms #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
      .sys_clk(sys_clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
      .req_rwb(req_rwb), .req_addr(req_addr), .req_data(req_data), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
   );

   spi_ms #(.CLK_DIV(1), .GAP_CYCLES(2)) dut1 (
      .sys_clk(sys_clk), .rstn(rstn), .req_valid(req_valid_1), .req_ready(req_ready_1),
      .req_rwb(req_rwb_1), .req_addr(req_addr_1), .req_data(req_data_1), .rsp_valid(rsp_valid_1),
      .rsp_data(rsp_data_1), .sclk(sclk_1), .cs_n(cs_n_1), .mosi(mosi_1), .miso(miso_1)
   );

   // Reference model: the frame as a number and the reported field as plain arithmetic.
   function automatic logic [31:0] model_word(logic rwb, logic [5:0] addr, logic [11:0] data);
      return 32'(rwb) + 32'(addr) * 32'd256 + 32'(data) * 32'd65536;
   endfunction

   function automatic logic [11:0] model_rsp(logic [11:0] data, logic [31:0] miso_word);
      if (LOOPBACK) return data;
      return 12'((miso_word / 32'd65536) % 32'd4096);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic run_frame(input vec_t v, output obs_t o);
      logic prev;
      int   n;
      o.mosi_word = '0; o.cs_low = 0; o.rises = 0; o.pulses = 0;
      o.ready_hi = 0; o.rsp = '0; o.timeout = 1'b1;
      n = 0;
      while (!req_ready && n < 2000) begin
         @(negedge sys_clk);
         n++;
      end
      req_valid = 1'b1; req_rwb = v.rwb; req_addr = v.addr; req_data = v.data;
      miso = v.miso_word[0];
      prev = 1'b0;
      for (int c = 0; c < 5000; c++) begin
         @(negedge sys_clk);
         req_valid = 1'b0;
         if (req_ready) o.ready_hi++;
         if (rsp_valid) begin
            o.pulses++;
            o.rsp = rsp_data;
         end
         if (sclk && !prev) begin
            if (o.rises < 32) o.mosi_word[o.rises] = mosi;
            o.rises++;
            if (o.rises < 32) miso = v.miso_word[o.rises];
         end
         prev = sclk;
         if (cs_n) begin
            o.timeout = 1'b0;
            break;
         end
         o.cs_low++;
      end
      for (int k = 0; k < GAP_CYCLES; k++) begin
         @(negedge sys_clk);
         if (rsp_valid) o.pulses++;
         if (req_ready && k < GAP_CYCLES - 1) o.ready_hi++;
      end
   endtask

   task automatic check_frame(input string tag, input vec_t v, input obs_t o);
      check({tag, "_timeout"}, 32'(o.timeout), 32'd0);
      check({tag, "_mosi_word"}, o.mosi_word, v.exp_word);
      check({tag, "_cs_low_cycles"}, o.cs_low, 64 * CLK_DIV);
      check({tag, "_sclk_rises"}, o.rises, 32);
      check({tag, "_rsp_pulses"}, o.pulses, 1);
      check({tag, "_rsp_data"}, 32'(o.rsp), 32'(v.exp_rsp));
      check({tag, "_ready_busy"}, o.ready_hi, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tbl[4];
      vec_t v;
      obs_t o;
      int   n, rdy, gap, low, r, bad, last_c, pulses;
      logic prev;
      logic [31:0] w1;

      tbl[0] = '{rwb: 1'b0, addr: 6'd12, data: 12'hABC, miso_word: 32'h0,
                 exp_word: 32'h0ABC0C00, exp_rsp: LOOPBACK ? 12'hABC : 12'h000};
      tbl[1] = '{rwb: 1'b1, addr: 6'd12, data: 12'h000, miso_word: 32'h0DEF0000,
                 exp_word: 32'h00000C01, exp_rsp: LOOPBACK ? 12'h000 : 12'hDEF};
      tbl[2] = '{rwb: 1'b0, addr: 6'h3F, data: 12'h5A3, miso_word: 32'hFFFFFFFF,
                 exp_word: 32'h05A33F00, exp_rsp: LOOPBACK ? 12'h5A3 : 12'hFFF};
      tbl[3] = '{rwb: 1'b1, addr: 6'h00, data: 12'hFFF, miso_word: 32'hA5A5A5A5,
                 exp_word: 32'h0FFF0001, exp_rsp: LOOPBACK ? 12'hFFF : 12'h5A5};

      rstn = 1'b0; req_valid = 1'b1; req_rwb = 1'b0; req_addr = 6'd1; req_data = 12'h1;
      miso = 1'b0;
      req_valid_1 = 1'b0; req_rwb_1 = 1'b0; req_addr_1 = '0; req_data_1 = '0; miso_1 = 1'b0;
      repeat (3) @(negedge sys_clk);

      // Reset held with a request pending: reset must win.
      check("rst_cs_n", 32'(cs_n), 32'd1);
      check("rst_sclk", 32'(sclk), 32'd0);
      check("rst_mosi", 32'(mosi), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      rstn = 1'b1;
      @(negedge sys_clk);

      for (int i = 0; i < 4; i++) begin
         run_frame(tbl[i], o);
         check_frame($sformatf("dir%0d", i), tbl[i], o);
      end

      for (int i = 0; i < 6; i++) begin
         v.rwb       = 1'($urandom_range(0, 1));
         v.addr      = 6'($urandom_range(0, 63));
         v.data      = 12'($urandom_range(0, 4095));
         v.miso_word = $urandom;
         v.exp_word  = model_word(v.rwb, v.addr, v.data);
         v.exp_rsp   = model_rsp(v.data, v.miso_word);
         run_frame(v, o);
         check_frame($sformatf("rnd%0d", i), v, o);
      end

      // Back-to-back with req_valid held high.
      req_valid = 1'b1; req_rwb = 1'b0; req_addr = 6'd5; req_data = 12'h123; miso = 1'b0;
      n = 0;
      while (cs_n && n < 100) begin
         @(negedge sys_clk);
         n++;
      end
      check("b2b_first_start", 32'(cs_n), 32'd0);
      rdy = 0; n = 0;
      while (!cs_n && n < 1000) begin
         if (req_ready) rdy++;
         @(negedge sys_clk);
         n++;
      end
      gap = 0;
      while (cs_n && gap < 100) begin
         if (req_ready && gap < GAP_CYCLES) rdy++;
         @(negedge sys_clk);
         gap++;
      end
      req_valid = 1'b0;
      check("b2b_ready_low", rdy, 0);
      check("b2b_rise_to_fall", gap, GAP_CYCLES + 1);
      n = 0;
      while (!cs_n && n < 1000) begin
         @(negedge sys_clk);
         n++;
      end
      repeat (GAP_CYCLES + 1) @(negedge sys_clk);

      // Reset pulse while bit 10 is on the wire.
      req_valid = 1'b1; req_rwb = 1'b0; req_addr = 6'd12; req_data = 12'hABC;
      @(negedge sys_clk);
      req_valid = 1'b0;
      r = 0; n = 0; prev = 1'b0;
      while (r < 11 && n < 1000) begin
         if (sclk && !prev) r++;
         prev = sclk;
         if (r < 11) begin
            @(negedge sys_clk);
            n++;
         end
      end
      rstn = 1'b0;
      @(negedge sys_clk);
      rstn = 1'b1;
      check("midrst_cs_n", 32'(cs_n), 32'd1);
      check("midrst_sclk", 32'(sclk), 32'd0);
      check("midrst_mosi", 32'(mosi), 32'd0);
      check("midrst_req_ready", 32'(req_ready), 32'd1);
      pulses = 0;
      for (int k = 0; k < 2 * GAP_CYCLES; k++) begin
         if (rsp_valid) pulses++;
         @(negedge sys_clk);
      end
      check("midrst_no_rsp", pulses, 0);
      run_frame(tbl[0], o);
      check_frame("midrst_next", tbl[0], o);

      // CLK_DIV=1 instance.
      req_valid_1 = 1'b1; req_rwb_1 = 1'b1; req_addr_1 = 6'd33; req_data_1 = 12'h9C4;
      prev = 1'b0; low = 0; r = 0; bad = 0; last_c = -1; pulses = 0; rdy = 0; w1 = '0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge sys_clk);
         req_valid_1 = 1'b0;
         if (req_ready_1) rdy++;
         if (sclk_1 && !prev) begin
            if (last_c >= 0 && c - last_c != 2) bad++;
            if (r < 32) w1[r] = mosi_1;
            last_c = c;
            r++;
         end
         prev = sclk_1;
         if (rsp_valid_1) pulses++;
         if (cs_n_1) break;
         low++;
      end
      repeat (3) begin
         @(negedge sys_clk);
         if (rsp_valid_1) pulses++;
      end
      check("div1_cs_low_cycles", low, 64);
      check("div1_sclk_rises", r, 32);
      check("div1_bad_periods", bad, 0);
      check("div1_mosi_word", w1, model_word(1'b1, 6'd33, 12'h9C4));
      check("div1_ready_busy", rdy, 0);
      check("div1_rsp_pulses", pulses, 1);
      check("div1_rsp_data", 32'(rsp_data_1), 32'(model_rsp(12'h9C4, 32'h0)));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/spi_ms.md
SPI_MS -- requirements
Module: spi_ms

Interface
REQ-001 The block SHALL have one clock, sys_clk; the reset SHALL be rstn, synchronous and active-low.
REQ-002 The block SHALL have parameter CLK_DIV, default 2, giving sys_clk cycles per sclk half-period (legal range is 1 or more).
REQ-003 The block SHALL have parameter GAP_CYCLES, default 4, giving sys_clk cycles cs_n stays high after a frame (legal range is 1 or more).
REQ-004 Ports SHALL be, in order:
- sys_clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- req_valid  in  1  command request
- req_ready  out  1  block can accept a command
- req_rwb  in  1  1 = read, 0 = write
- req_addr  in  6  register address
- req_data  in  12  write data
- rsp_valid  out  1  one-cycle pulse, frame complete
- rsp_data  out  12  received data field
- sclk  out  1  SPI clock, idles low
- cs_n  out  1  chip select, active-low
- mosi  out  1  serial out
- miso  in  1  serial in

Function
REQ-005 The command word SHALL be 32 bits, sent LSB first, laid out as follows:
- bit 0 = rwb
- bits [7:1] = 0
- bits [13:8] = addr
- bits [15:14] = 0
- bits [27:16] = data
- bits [31:28] = 0
REQ-006 The FSM SHALL have the states IDLE, LOW, HIGH and GAP.
REQ-007 In IDLE, the block SHALL drive req_ready=1, cs_n=1 and sclk=0.
REQ-008 A transfer SHALL be accepted on req_valid and req_ready both high at a clock edge; at that edge the block SHALL latch the word, set the bit counter to 0, drive cs_n=0 and mosi=word[0], and enter LOW.
REQ-009 The block SHALL drive req_ready=0 in LOW, HIGH and GAP; req_valid in those states SHALL be ignored.
REQ-010 LOW SHALL hold sclk=0 for CLK_DIV cycles, then raise sclk, sample miso into rx[bit_cnt] on that same edge, and enter HIGH.
REQ-011 HIGH SHALL hold sclk=1 for CLK_DIV cycles. Then, if bit_cnt<31, the block SHALL increment bit_cnt, drive sclk=0 and mosi=word[bit_cnt+1], and enter LOW. If bit_cnt=31, it SHALL drive sclk=0, cs_n=1 and mosi=0, and enter GAP.
REQ-012 On GAP entry, the block SHALL pulse rsp_valid for one cycle, with rsp_data = rx[27:16] held until the next rsp_valid; this SHALL happen for both reads and writes.
REQ-013 GAP SHALL last GAP_CYCLES cycles, then return to IDLE.
REQ-014 cs_n SHALL be low for exactly 64*CLK_DIV cycles per frame, with exactly 32 sclk rising edges.
REQ-015 mosi SHALL change only while sclk is low.
REQ-016 The bit counter SHALL be 5 bits and SHALL stop at 31 without wrapping.

Reset
REQ-017 While rstn=0 at a clock edge, the block SHALL enter IDLE with cs_n=1, sclk=0, mosi=0, rsp_valid=0, rsp_data=0, bit_cnt=0 and req_ready=1 after that edge.
REQ-018 A reset in mid-frame SHALL abort the frame with no rsp_valid pulse; the next accepted request SHALL send a full 32-bit frame.
REQ-019 Reset SHALL take priority over an acceptance in the same cycle.

Configuration
REQ-020 When SPI_MS_LOOPBACK_EN is defined, the miso input SHALL be ignored and the sampled bit SHALL be the internal mosi value, so that rsp_data equals the sent data field.
REQ-021 When SPI_MS_LOOPBACK_EN is not defined, the block SHALL sample the miso pin.

Structure
REQ-022 Package spi_pkg SHALL hold:
- the frame field position constants (RWB_BIT, ADDR_LSB, DATA_LSB, WORD_W=32);
- the state_t enum;
- the function build_cmd_word(rwb, addr, data).
REQ-023 The half-period counter SHALL be the sub-module spi_ms_tick, with inputs sys_clk, rstn and en, a parameter for the divide count, and output tick.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Write addr=12, data=0xABC, rwb=0 -> mosi sampled on sclk rising edges, LSB first, equals 0x0ABC0C00; cs_n low for 128 cycles; one rsp_valid pulse.
- Read addr=12 with miso model returning 0x0DEF0000 -> rsp_valid pulse with rsp_data=0xDEF.
- Back-to-back requests with req_valid held high -> req_ready=0 through frame and gap; second cs_n fall occurs GAP_CYCLES+1 cycles after first cs_n rise.
- rstn=0 for one cycle during bit 10 -> next cycle cs_n=1, sclk=0, no rsp_valid; following write sends full frame 0x0ABC0C00.
- CLK_DIV=1 -> cs_n low for 64 cycles, sclk period 2 cycles.
- SPI_MS_LOOPBACK_EN defined, write data=0x5A3 -> rsp_data=0x5A3.
